// File: rtl/button_conditioner.sv
// Pushbutton conditioner: synchronizer, debounce FSM and one-cycle press pulse.
// Define AUTO_REPEAT_EN to get auto-repeat pulses while the button is held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic game_charge,
    output logic btn_level
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          pulse_next;
    logic          s1, s2;
`ifdef AUTO_REPEAT_EN
    logic          repeating, repeating_next;
`endif

    // Synchronizer resets to the released level so a held button looks like a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= btn_n;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            game_charge <= 1'b0;
`ifdef AUTO_REPEAT_EN
            repeating   <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            game_charge <= pulse_next;
`ifdef AUTO_REPEAT_EN
            repeating   <= repeating_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pulse_next = 1'b0;
`ifdef AUTO_REPEAT_EN
        repeating_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (!s2) state_next = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (s2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (s2) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end else begin
`ifdef AUTO_REPEAT_EN
                    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
                    repeating_next = repeating;
                    if (cnt == (repeating ? RP_LAST : RD_LAST)) begin
                        cnt_next       = '0;
                        repeating_next = 1'b1;
                        pulse_next     = ~game_charge;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
`else
                    cnt_next = '0;
`endif
                end
            end
            RELEASE_WAIT: begin
                if (!s2) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign btn_level = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: run-length reference model feeds a queue
// of expected outputs that a negedge monitor compares against the DUT each cycle.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk;
    logic rst_n;
    logic btn_n;
    logic game_charge;
    logic btn_level;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic pulse;
        logic level;
    } exp_t;

    exp_t exp_q[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_n      (btn_n),
        .game_charge(game_charge),
        .btn_level  (btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: input seen two edges late; a level flips once D+1 consecutive
    // samples disagree with it; hold time since (re)entering pressed drives repeats.
    logic m_s1 = 1'b1, m_s2 = 1'b1, m_level = 1'b0, m_rep = 1'b0;
    int   m_run = 0, m_hold = 0;

    always @(posedge clk) begin
        logic x;
        logic pulse;
        if (!rst_n) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0;
            m_run = 0; m_hold = 0; m_rep = 1'b0;
        end else begin
            x = m_s2;
            m_s2 = m_s1;
            m_s1 = btn_n;
            pulse = 1'b0;
            if (x == m_level) begin
                m_run = m_run + 1;
                if (m_run == DB + 1) begin
                    m_level = ~m_level;
                    m_run = 0; m_hold = 0; m_rep = 1'b0;
                    pulse = m_level;
                end
            end else if (m_run > 0) begin
                m_run = 0; m_hold = 0; m_rep = 1'b0;
            end else if (m_level) begin
`ifdef AUTO_REPEAT_EN
                m_hold = m_hold + 1;
                if (m_hold == (m_rep ? RP : RD)) begin
                    pulse = 1'b1;
                    m_hold = 0;
                    m_rep = 1'b1;
                end
`endif
            end
            exp_q.push_back('{pulse: pulse, level: m_level});
        end
    end

    task automatic check_output(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        e = '{pulse: 1'b0, level: 1'b0};
        if (!rst_n) exp_q.delete();
        else if (exp_q.size() > 0) e = exp_q.pop_front();
        check_output("game_charge", game_charge, e.pulse);
        check_output("btn_level", btn_level, e.level);
    end

    task automatic apply_stimulus(input logic lvl, input int cycles);
        btn_n = lvl;
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_reset(input logic lvl, input int cycles);
        rst_n = 1'b0;
        apply_stimulus(lvl, cycles);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        btn_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        apply_stimulus(1'b1, 3);

        apply_stimulus(1'b0, 20);
        apply_stimulus(1'b1, 10);

        apply_stimulus(1'b0, 2);
        apply_stimulus(1'b1, 1);
        apply_stimulus(1'b0, 10);
        apply_stimulus(1'b1, 10);

        apply_stimulus(1'b0, 10);
        apply_stimulus(1'b1, 2);
        apply_stimulus(1'b0, 5);
        apply_stimulus(1'b1, 6);
        apply_stimulus(1'b1, 4);

        apply_stimulus(1'b0, 10);
        pulse_reset(1'b0, 2);
        apply_stimulus(1'b0, 12);
        apply_stimulus(1'b1, 10);

        apply_stimulus(1'b0, 40);
        apply_stimulus(1'b1, 10);

        for (int i = 0; i < 300; i++) begin
            logic lvl;
            int   n;
            lvl = logic'($urandom_range(0, 1));
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 35)) : int'($urandom_range(1, 8));
            if ($urandom_range(0, 39) == 0)
                pulse_reset(lvl, int'($urandom_range(1, 3)));
            apply_stimulus(lvl, n);
        end

        apply_stimulus(1'b1, 10);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
